// File: rtl/keypad_scan_fifo_if.sv
// CPU-side port of the keypad block: mode select, ack level and the 16-bit read word.
interface keypad_scan_fifo_if;
   logic        statusordata;
   logic        ack;
   logic [15:0] keyout;

   modport master (
      output statusordata,
      output ack,
      input  keyout
   );

   modport slave (
      input  statusordata,
      input  ack,
      output keyout
   );
endinterface

// File: rtl/keypad_scan_fifo.sv
// 4x4 matrix keypad scanner with press/release debounce and a key-code FIFO read by the CPU.
module keypad_scan_fifo #(
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned DEB_CYCLES = 50000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [3:0]          rowwrite,
   input  logic [3:0]          colread,
   keypad_scan_fifo_if.slave   bus
);

   localparam int unsigned ScanW = $clog2(SCAN_DIV + 1);
   localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StScan, StDebounce, StPush, StRelease} state_e;

   state_e           state_q, state_d;
   logic [1:0]       row_q, row_d;
   logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
   logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
   logic [3:0]       code_q, code_d;
   logic [3:0]       pat_q, pat_d;
   logic             push;

   logic [3:0]       mem [FIFO_DEPTH];
   logic [AddrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AddrW:0]   count_q;
   logic             overflow_q, ack_d_q;
   logic             full, not_empty, pop_req, do_pop, do_write, drop;

   logic       col_valid;
   logic [1:0] col_idx;

   // Exactly one low column counts as a key; anything else is "no key".
   always_comb begin
      col_valid = 1'b1;
      col_idx   = 2'd0;
      case (colread)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StScan;
         row_q      <= 2'd0;
         scan_cnt_q <= '0;
         deb_cnt_q  <= '0;
         code_q     <= 4'd0;
         pat_q      <= 4'hF;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         scan_cnt_q <= scan_cnt_d;
         deb_cnt_q  <= deb_cnt_d;
         code_q     <= code_d;
         pat_q      <= pat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      scan_cnt_d = scan_cnt_q;
      deb_cnt_d  = deb_cnt_q;
      code_d     = code_q;
      pat_d      = pat_q;
      unique case (state_q)
         StScan: begin
            if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
               scan_cnt_d = '0;
               if (col_valid) begin
                  state_d   = StDebounce;
                  deb_cnt_d = '0;
                  code_d    = {row_q, col_idx};
                  pat_d     = colread;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end else begin
               scan_cnt_d = scan_cnt_q + ScanW'(1);
            end
         end
         StDebounce: begin
            if (colread != pat_q) begin
               state_d    = StScan;
               row_d      = row_q + 2'd1;
               scan_cnt_d = '0;
            end else if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
               state_d = StPush;
            end else begin
               deb_cnt_d = deb_cnt_q + DebW'(1);
            end
         end
         StPush: begin
            state_d   = StRelease;
            deb_cnt_d = '0;
         end
         StRelease: begin
            if (colread != 4'hF) begin
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
               state_d    = StScan;
               row_d      = row_q + 2'd1;
               scan_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DebW'(1);
            end
         end
         default: state_d = StScan;
      endcase
   end

   always_comb begin
      rowwrite = ~(4'b0001 << row_q);
      push     = (state_q == StPush);
   end

   assign full      = (count_q == (AddrW + 1)'(FIFO_DEPTH));
   assign not_empty = (count_q != '0);
   assign pop_req   = bus.ack & ~ack_d_q;
   assign do_pop    = pop_req & not_empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
   assign do_write  = push & (~full | do_pop);
   assign drop      = push & full & ~do_pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         ack_d_q    <= 1'b0;
      end else begin
         ack_d_q <= bus.ack;
         if (do_write) wr_ptr_q <= wr_ptr_q + AddrW'(1);
         if (do_pop)   rd_ptr_q <= rd_ptr_q + AddrW'(1);
         if (do_write && !do_pop) begin
            count_q <= count_q + (AddrW + 1)'(1);
         end else if (!do_write && do_pop) begin
            count_q <= count_q - (AddrW + 1)'(1);
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (do_pop) begin
            overflow_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_write) mem[wr_ptr_q] <= code_q;
   end

   always_comb begin
      if (bus.statusordata) begin
         bus.keyout = {13'b0, overflow_q, full, not_empty};
      end else if (not_empty) begin
         bus.keyout = {12'b0, mem[rd_ptr_q]};
      end else begin
         bus.keyout = 16'h0000;
      end
   end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: keypad model on rowwrite/colread, CPU reads checked against a queue.
module tb_keypad_scan_fifo;

   localparam int unsigned ScanDiv   = 4;
   localparam int unsigned DebCycles = 8;
   localparam int unsigned FifoDepth = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rowwrite;
   logic [3:0] colread;

   logic [1:0] key_row;
   logic [3:0] key_pat;
   logic       key_on;

   logic [3:0] exp_q [$];
   logic       exp_ovf;
   int         n_checks = 0;
   int         n_errors = 0;

   keypad_scan_fifo_if bus ();

   keypad_scan_fifo #(
      .SCAN_DIV   (ScanDiv),
      .DEB_CYCLES (DebCycles),
      .FIFO_DEPTH (FifoDepth)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rowwrite (rowwrite),
      .colread  (colread),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Pressed key pulls its column low only while its row is driven.
   assign colread = (key_on && rowwrite[key_row] == 1'b0) ? key_pat : 4'hF;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_status();
      return {13'b0, exp_ovf, exp_q.size() == FifoDepth, exp_q.size() != 0};
   endfunction

   task automatic model_push(input logic [3:0] code);
      if (exp_q.size() < FifoDepth) exp_q.push_back(code);
      else exp_ovf = 1'b1;
   endtask

   task automatic check_status(input string tag);
      bus.statusordata = 1'b1;
      #1;
      check_eq(tag, bus.keyout, exp_status());
   endtask

   task automatic check_data_empty(input string tag);
      bus.statusordata = 1'b0;
      #1;
      check_eq(tag, bus.keyout, 16'h0000);
   endtask

   // Data read; keyout is compared during ack's first cycle, ack then held 3 cycles.
   task automatic cpu_pop(input string tag);
      logic [15:0] exp;
      bus.statusordata = 1'b0;
      bus.ack = 1'b1;
      #1;
      exp = (exp_q.size() != 0) ? {12'b0, exp_q[0]} : 16'h0000;
      check_eq(tag, bus.keyout, exp);
      if (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         exp_ovf = 1'b0;
      end
      step(3);
      bus.ack = 1'b0;
      step(1);
   endtask

   task automatic press(input logic [1:0] row, input logic [1:0] col, input int hold);
      key_row = row;
      key_pat = ~(4'b0001 << col);
      key_on  = 1'b1;
      step(hold);
      key_on = 1'b0;
      step(20);
      model_push({row, col});
   endtask

   // Press a key while its row is idle, return just after the edge that starts driving it.
   task automatic arm_key(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] target;
      target  = ~(4'b0001 << row);
      key_row = row;
      key_pat = ~(4'b0001 << col);
      for (int i = 0; i < 20; i++) begin
         if (rowwrite != target) break;
         step(1);
      end
      key_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (rowwrite == target) break;
      end
      check_eq("row_sync", {12'b0, rowwrite}, {12'b0, target});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [3:0] prev;
      int         n_rot;

      bus.statusordata = 1'b0;
      bus.ack = 1'b0;
      key_on  = 1'b0;
      key_row = 2'd0;
      key_pat = 4'hF;
      exp_ovf = 1'b0;
      rst_n   = 1'b0;
      step(2);
      rst_n = 1'b1;

      check_eq("rst_row", {12'b0, rowwrite}, 16'h000E);
      check_status("rst_status");
      check_data_empty("rst_data");

      // Single press queued once
      press(2'd2, 2'd1, 40);
      check_status("t1_status");
      cpu_pop("t1_data");
      check_status("t1_after");

      // Bouncing contact never accepted
      key_row = 2'd0;
      key_pat = 4'b1110;
      for (int i = 0; i < 10; i++) begin
         key_on = ~key_on;
         step(3);
      end
      key_on = 1'b0;
      step(30);
      check_status("t2_status");

      // Five keys into a 4-deep FIFO
      press(2'd0, 2'd0, 40);
      press(2'd1, 2'd1, 40);
      press(2'd2, 2'd2, 40);
      press(2'd3, 2'd3, 40);
      press(2'd0, 2'd3, 40);
      check_status("t3_full");
      cpu_pop("t3_pop0");
      check_status("t3_after1");
      cpu_pop("t3_pop1");
      cpu_pop("t3_pop2");
      cpu_pop("t3_pop3");
      check_status("t3_empty");

      // Two columns low: ignored, rows keep rotating
      key_row = 2'd1;
      key_pat = 4'b1100;
      key_on  = 1'b1;
      prev    = rowwrite;
      n_rot   = 0;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (rowwrite != prev) begin
            check_eq("t4_rot", {12'b0, rowwrite}, {12'b0, prev[2:0], prev[3]});
            prev = rowwrite;
            n_rot++;
         end
      end
      check_eq("t4_rot_count", {15'b0, n_rot >= 12}, 16'h0001);
      key_on = 1'b0;
      step(5);
      check_status("t4_status");

      // Full FIFO: push and pop in the same cycle
      press(2'd0, 2'd1, 40);
      press(2'd0, 2'd2, 40);
      press(2'd1, 2'd0, 40);
      press(2'd2, 2'd0, 40);
      check_status("t5_full");
      arm_key(2'd1, 2'd2);
      step(12);
      bus.statusordata = 1'b0;
      bus.ack = 1'b1;
      #1;
      check_eq("t5_prepop", bus.keyout, {12'b0, exp_q[0]});
      void'(exp_q.pop_front());
      exp_q.push_back(4'd6);
      step(3);
      bus.ack = 1'b0;
      step(10);
      key_on = 1'b0;
      step(20);
      check_status("t5_still_full");
      cpu_pop("t5_pop0");
      cpu_pop("t5_pop1");
      cpu_pop("t5_pop2");
      cpu_pop("t5_pop3");
      check_status("t5_empty");

      // Reset during debounce discards the pending key
      arm_key(2'd2, 2'd3);
      step(6);
      rst_n  = 1'b0;
      key_on = 1'b0;
      step(1);
      rst_n = 1'b1;
      check_eq("t6_row", {12'b0, rowwrite}, 16'h000E);
      check_status("t6_status");
      check_data_empty("t6_data");
      step(40);
      check_status("t6_not_queued");

      // Reset with two entries queued
      press(2'd3, 2'd0, 40);
      press(2'd1, 2'd3, 40);
      check_status("t6_two");
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      exp_q.delete();
      exp_ovf = 1'b0;
      check_eq("t6b_row", {12'b0, rowwrite}, 16'h000E);
      check_status("t6b_status");
      check_data_empty("t6b_data");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
